// File: rtl/alarm_chime_pkg.sv
// Shared types and helpers for the alarm chime driver.
// Holds the state enum, counter width helper and parameter floor values.
package alarm_chime_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUAL,
    S_ON,
    S_OFF,
    S_MUTE
  } chime_state_e;

  localparam int MIN_DEBOUNCE = 1;
  localparam int MIN_ON       = 1;
  localparam int MIN_OFF      = 1;
  localparam int MIN_BEEPS    = 1;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int at_least(input int v, input int lo);
    return (v < lo) ? lo : v;
  endfunction

endpackage

// File: rtl/chime_timer.sv
// Loadable down-counter timing both the ON and OFF phases of a beep.
// expire is high during the last cycle of a loaded interval.
module chime_timer
  import alarm_chime_pkg::*;
#(
  parameter int MAX_CYCLES = 4,
  parameter int W          = cnt_w(MAX_CYCLES)
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expire
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign expire = (r_cnt == W'(1));

endmodule

// File: rtl/alarm_chime_driver.sv
// Qualifies the Alarm level and drives a cadenced buzzer, then mutes.
// Define ALARM_ACK_EN to let Ack silence the beeps early.
module alarm_chime_driver
  import alarm_chime_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int ON_CYCLES       = 4,
  parameter int OFF_CYCLES      = 4,
  parameter int BEEP_COUNT      = 5
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic                            Alarm,
  input  logic                            Ack,
  output logic                            Buzzer,
  output logic                            Active,
  output logic                            Muted,
  output logic [$clog2(BEEP_COUNT+1)-1:0] BeepCnt
);

  localparam int D_EFF = at_least(DEBOUNCE_CYCLES, MIN_DEBOUNCE);
  localparam int ON_EFF = at_least(ON_CYCLES, MIN_ON);
  localparam int OFF_EFF = at_least(OFF_CYCLES, MIN_OFF);
  localparam int N_EFF = at_least(BEEP_COUNT, MIN_BEEPS);

  localparam int QW = cnt_w(D_EFF);
  localparam int BW = $clog2(BEEP_COUNT + 1);
  localparam int TMAX = (ON_EFF > OFF_EFF) ? ON_EFF : OFF_EFF;
  localparam int TW = cnt_w(TMAX);

  localparam logic [QW-1:0] QLAST = QW'(D_EFF);
  localparam logic [BW-1:0] BLAST = BW'(N_EFF);

  chime_state_e r_state;
  chime_state_e w_nxt;
  logic [QW-1:0] r_qcnt;
  logic [BW-1:0] r_bcnt;
  logic          r_buzzer;
  logic          r_active;
  logic          r_muted;
  logic          w_ack;
  logic          w_exp;
  logic          w_load;
  logic [TW-1:0] w_lval;

`ifdef ALARM_ACK_EN
  assign w_ack = Ack;
`else
  logic w_unused_ack;
  assign w_unused_ack = Ack;
  assign w_ack = 1'b0;
`endif

  // Alarm release outranks Ack, which outranks the phase timer.
  always_comb begin
    w_nxt = r_state;
    if (!Alarm) begin
      w_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: w_nxt = (D_EFF == 1) ? S_ON : S_QUAL;
        S_QUAL: if (r_qcnt + QW'(1) == QLAST) w_nxt = S_ON;
        S_ON: begin
          if (w_ack) w_nxt = S_MUTE;
          else if (w_exp) w_nxt = S_OFF;
        end
        S_OFF: begin
          if (w_ack) w_nxt = S_MUTE;
          else if (w_exp)
            w_nxt = (r_bcnt == BLAST) ? S_MUTE : S_ON;
        end
        S_MUTE: w_nxt = S_MUTE;
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  // ON and OFF always alternate, so any entry into either reloads.
  assign w_load = (w_nxt == S_ON || w_nxt == S_OFF)
                  && (w_nxt != r_state);
  assign w_lval = (w_nxt == S_ON) ? TW'(ON_EFF) : TW'(OFF_EFF);

  chime_timer #(
    .MAX_CYCLES (TMAX),
    .W          (TW)
  ) u_timer (
    .Clk        (Clk),
    .Rst        (Rst),
    .load       (w_load),
    .load_value (w_lval),
    .expire     (w_exp)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state  <= S_IDLE;
      r_qcnt   <= '0;
      r_bcnt   <= '0;
      r_buzzer <= 1'b0;
      r_active <= 1'b0;
      r_muted  <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_qcnt   <= (w_nxt == S_QUAL) ? r_qcnt + QW'(1) : '0;
      if (w_nxt == S_IDLE)
        r_bcnt <= '0;
      else if (r_state == S_ON && w_nxt == S_OFF)
        r_bcnt <= r_bcnt + BW'(1);
      r_buzzer <= (w_nxt == S_ON);
      r_active <= (w_nxt != S_IDLE);
      r_muted  <= (w_nxt == S_MUTE);
    end
  end

  assign Buzzer  = r_buzzer;
  assign Active  = r_active;
  assign Muted   = r_muted;
  assign BeepCnt = r_bcnt;

endmodule

// File: tb/tb_alarm_chime_driver.sv
// Bench for alarm_chime_driver: directed scenarios plus random Alarm/Ack/Rst.
// Expected outputs come from an arithmetic model of the beep cadence.
module tb_alarm_chime_driver;

  localparam int D   = 3;
  localparam int ON  = 4;
  localparam int OFF = 4;
  localparam int N   = 5;
  localparam int P   = ON + OFF;
  localparam int BW  = $clog2(N + 1);

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          Alarm = 1'b0;
  logic          Ack = 1'b0;
  logic          Buzzer;
  logic          Active;
  logic          Muted;
  logic [BW-1:0] BeepCnt;

  int n_checks = 0;
  int n_errors = 0;

  int s = 0;
  bit ackm = 1'b0;
  int e_bz = 0;
  int e_act = 0;
  int e_mu = 0;
  int e_bc = 0;

  alarm_chime_driver #(
    .DEBOUNCE_CYCLES (D),
    .ON_CYCLES       (ON),
    .OFF_CYCLES      (OFF),
    .BEEP_COUNT      (N)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Alarm   (Alarm),
    .Ack     (Ack),
    .Buzzer  (Buzzer),
    .Active  (Active),
    .Muted   (Muted),
    .BeepCnt (BeepCnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s obs=%0d exp=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // s = consecutive high Alarm samples since the last low or reset.
  // Beeping starts once s reaches D; t counts cycles since first rise.
  function automatic void model(input bit a, input bit k, input bit r);
    bit beeping;
    int t;
    if (r || !a) begin
      s = 0;
      ackm = 1'b0;
    end else begin
      beeping = (s >= D) && (s - D < N * P) && !ackm;
      s++;
`ifdef ALARM_ACK_EN
      if (k && beeping) ackm = 1'b1;
`else
      if (k && beeping) ackm = 1'b0;
`endif
    end
    if (s == 0) begin
      e_bz = 0; e_act = 0; e_mu = 0; e_bc = 0;
    end else if (ackm) begin
      e_bz = 0; e_act = 1; e_mu = 1;
    end else if (s < D) begin
      e_bz = 0; e_act = 1; e_mu = 0; e_bc = 0;
    end else begin
      t = s - D;
      e_act = 1;
      if (t < N * P) begin
        e_bz = ((t % P) < ON) ? 1 : 0;
        e_bc = t / P + (((t % P) >= ON) ? 1 : 0);
        e_mu = 0;
      end else begin
        e_bz = 0; e_mu = 1; e_bc = N;
      end
    end
  endfunction

  task automatic cyc(input bit a, input bit k, input bit r);
    Alarm = a;
    Ack = k;
    Rst = r;
    @(posedge Clk);
    model(a, k, r);
    @(negedge Clk);
    chk("Buzzer", int'(Buzzer), e_bz);
    chk("Active", int'(Active), e_act);
    chk("Muted", int'(Muted), e_mu);
    chk("BeepCnt", int'(BeepCnt), e_bc);
  endtask

  task automatic run(input int n, input bit a, input bit k, input bit r);
    for (int i = 0; i < n; i++) cyc(a, k, r);
  endtask

  initial begin
    bit ra;
    bit rk;
    bit rr;
    @(negedge Clk);
    run(2, 1'b0, 1'b0, 1'b1);
    // Short glitch never beeps.
    run(2, 1'b1, 1'b0, 1'b0);
    run(3, 1'b0, 1'b0, 1'b0);
    // Full sequence to auto-mute.
    run(3 + N * P + 6, 1'b1, 1'b0, 1'b0);
    run(2, 1'b0, 1'b0, 1'b0);
    // Drop during the second ON phase.
    run(D + P + 2, 1'b1, 1'b0, 1'b0);
    run(2, 1'b0, 1'b0, 1'b0);
    // Ack during the second OFF phase.
    run(D + P + ON + 1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    run(P * 4, 1'b1, 1'b0, 1'b0);
    run(2, 1'b0, 1'b0, 1'b0);
    // Reset mid-ON, then requalify with Alarm held.
    run(D + 2, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    run(D + P + 3, 1'b1, 1'b0, 1'b0);
    // Ack and Alarm release on the same edge.
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    run(2, 1'b0, 1'b0, 1'b0);
    // Random traffic.
    ra = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (ra) ra = ($urandom_range(0, 39) != 0);
      else ra = ($urandom_range(0, 3) == 0);
      rk = ($urandom_range(0, 24) == 0);
      rr = ($urandom_range(0, 299) == 0);
      cyc(ra, rk, rr);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alarm_chime_driver.md
# alarm_chime_driver

Sequential back end for the seat-belt/door warning: consumes the level `Alarm` request from the car-warning logic and turns it into a cadenced buzzer drive. It qualifies the request, emits a fixed number of on/off beeps, then mutes until the request clears. An optional driver acknowledge silences it early. It sits between the combinational warning logic and the buzzer output pin.

## Interface
- `DEBOUNCE_CYCLES`, default 3: consecutive high samples of `Alarm` required before beeping; must be ≥1.
- `ON_CYCLES`, default 4: cycles the buzzer is high per beep; must be ≥1.
- `OFF_CYCLES`, default 4: cycles the buzzer is low between beeps; must be ≥1.
- `BEEP_COUNT`, default 5: beeps emitted before auto-mute; must be ≥1.
- `Clk`  in  1  the only clock; all state changes on its rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `Alarm`  in  1  warning request level, synchronous to `Clk`.
- `Ack`  in  1  driver silence request, one-cycle or level; honoured only with `ALARM_ACK_EN`.
- `Buzzer`  out  1  buzzer drive, registered.
- `Active`  out  1  high whenever state ≠ IDLE.
- `Muted`  out  1  high in MUTE.
- `BeepCnt`  out  `$clog2(BEEP_COUNT+1)`  beeps completed since the last IDLE.

## Operation
- States: IDLE, QUAL, ON, OFF, MUTE. Outputs are Moore decodes of registered state: `Buzzer`=ON, `Muted`=MUTE, `Active`=not IDLE.
- Reset: state IDLE, all counters 0, so `Buzzer`=0, `Active`=0, `Muted`=0, `BeepCnt`=0. Reset mid-beep forces these values on the next edge.
- IDLE: if `Alarm`=1 → QUAL with qualify count 1. If `DEBOUNCE_CYCLES`=1, go directly → ON instead.
- QUAL: if `Alarm`=0 → IDLE, count cleared. Otherwise increment the count; on reaching `DEBOUNCE_CYCLES` → ON, with the timer loaded to `ON_CYCLES`.
- ON: the timer counts down. On expiry: `BeepCnt`+1 → OFF, timer loaded to `OFF_CYCLES`.
- OFF: on timer expiry, if `BeepCnt`==`BEEP_COUNT` → MUTE; otherwise → ON.
- MUTE: buzzer low and holds until `Alarm`=0 → IDLE.
- `Alarm`=0 in ON, OFF or MUTE → IDLE on the next edge. `BeepCnt` clears in IDLE.
- Priority per edge: `Rst` > `Alarm`=0 > `Ack` > timer expiry.
- `Alarm` glitches shorter than `DEBOUNCE_CYCLES` never produce `Buzzer`=1.

## Timing
- Latency: `Buzzer` rises after the edge on which `Alarm` has been sampled high for the `DEBOUNCE_CYCLES`-th consecutive time. With defaults this is 3 edges.
- Each beep is exactly `ON_CYCLES` high, followed by exactly `OFF_CYCLES` low.
- Full default sequence from first `Buzzer` rise to `Muted` rise: 5×(4+4) = 40 cycles.
- Alarm release: `Buzzer`, `Active` and `Muted` are 0 one cycle after `Alarm` is sampled low.
- `Ack` (with macro): sampled high in ON or OFF → MUTE on the next edge; `Buzzer` drops that edge.
- `Ack` in IDLE, QUAL or MUTE is ignored.

## Configuration
- `ALARM_ACK_EN` defined: `Ack` is honoured as described above.
- `ALARM_ACK_EN` undefined: the `Ack` port remains and is ignored; MUTE is reached only via `BEEP_COUNT`.

## Structure
- `alarm_chime_pkg` holds:
  - the state enum (IDLE, QUAL, ON, OFF, MUTE);
  - the counter width helper;
  - shared parameter-legality constants.
- Sub-module `chime_timer`: loadable down-counter with `load`, `load_value` and `expire` ports, sized to max(`ON_CYCLES`, `OFF_CYCLES`). It serves both the ON and OFF phases.
- The qualify counter and `BeepCnt` are inline in the top level.

## Test plan
- Defaults, `Alarm` high 2 cycles then low → `Buzzer` stays 0, `Active` returns to 0, `BeepCnt`=0.
- Defaults, `Alarm` held high → first `Buzzer` rise on the 3rd sampled edge; 5 pulses of 4 high / 4 low; `Muted`=1 with `BeepCnt`=5 and `Buzzer` 0 thereafter.
- `Alarm` dropped during the 2nd ON phase → next edge `Buzzer`=0, `Active`=0, `BeepCnt`=0.
- `ALARM_ACK_EN` defined, `Ack` pulsed during the 2nd OFF phase → `Muted`=1 next edge, `BeepCnt`=2, no further beeps. Without the macro → all 5 beeps occur.
- `Rst` asserted during an ON phase → next edge all outputs 0. After release with `Alarm` still high → requalifies and restarts at `BeepCnt`=0.
- `Ack` and `Alarm`=0 sampled on the same edge → IDLE (`Muted`=0, `Active`=0).
